param_shift_pipeline: RTL and testbench

PARAM_SHIFT_PIPELINE -- requirements
Module: param_shift_pipeline

---
 rtl/param_shift_pipeline.sv | 128 ++++++++++++
 tb/tb_param_shift_pipeline.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_shift_pipeline.sv
// Elastic DEPTH-stage pipeline applying a per-item step (pass/rotl/shr/inc) on entry to each stage.
// Optional PIPE_STATS_EN adds a saturating 16-bit output-transfer counter on port item_count.
module param_shift_pipeline #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out
`ifdef PIPE_STATS_EN
  ,
  output logic [15:0]      item_count
`endif
);

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic [1:0] m);
    logic [WIDTH-1:0] r;
    case (m)
      2'b00:   r = d;
      2'b01:   r = {d[WIDTH-2:0], d[WIDTH-1]};
      2'b10:   r = {1'b0, d[WIDTH-1:1]};
      default: r = d + WIDTH'(1);
    endcase
    return r;
  endfunction

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [1:0]       mode_q [DEPTH];
  logic [1:0]       mode_d [DEPTH];

  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] src_data [DEPTH];
  logic [1:0]       src_mode [DEPTH];

  // Walk from the output back to the input: a stage may move if the one after it is free.
  always_comb begin : stall_chain
    logic down_free;
    logic a;
    down_free = out_ready;
    a         = 1'b0;
    adv       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      a         = valid_q[i] & down_free;
      adv[i]    = a;
      down_free = ~valid_q[i] | a;
    end
    in_ready = down_free | flush;
  end

  assign load[0]     = in_valid & in_ready & ~flush;
  assign src_data[0] = data_in;
  assign src_mode[0] = mode;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_link
      assign load[gi]     = adv[gi-1];
      assign src_data[gi] = data_q[gi-1];
      assign src_mode[gi] = mode_q[gi-1];
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = flush ? 1'b0 : (load[i] | (valid_q[i] & ~adv[i]));
      data_d[i]  = data_q[i];
      mode_d[i]  = mode_q[i];
      if (load[i]) begin
        data_d[i] = step(src_data[i], src_mode[i]);
        mode_d[i] = src_mode[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        mode_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
        mode_q[i] <= mode_d[i];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign data_out  = data_q[DEPTH-1];

`ifdef PIPE_STATS_EN
  logic [15:0] count_q, count_d;

  // A flush wins over a same-cycle output transfer, so nothing is counted then.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (out_valid && out_ready && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign item_count = count_q;
`endif

endmodule

// File: tb/tb_param_shift_pipeline.sv
// Directed bench for param_shift_pipeline (WIDTH=8, DEPTH=4): latency, ordering, stall, bubbles, flush, reset.
// Define PIPE_STATS_EN for both files to also exercise item_count.
module tb_param_shift_pipeline;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_in;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data_out;
`ifdef PIPE_STATS_EN
  logic [15:0] item_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] got_q[$];

  param_shift_pipeline #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
`ifdef PIPE_STATS_EN
    ,
    .item_count(item_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  // Hold out_ready high and gather up to n outputs, bounded by a cycle budget.
  task automatic collect(input int n);
    got_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got_q.size() < n; c++) begin
      if (out_valid) got_q.push_back(data_out);
      @(negedge clk);
    end
    check("collect_count", got_q.size(), n);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int nout;
    logic [7:0] exp2 [4];
    logic [7:0] exp4 [3];

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; data_in = '0; mode = '0; out_ready = 1'b0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_data_out", data_out, 0);

    // A5 rotated left by 4 arrives exactly 4 edges after acceptance.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; data_in = 8'hA5; mode = 2'b01;
    #1 check("t1_in_ready", in_ready, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("t1_out_valid_e%0d", k), out_valid, (k == 4));
    end
    check("t1_data", data_out, 8'h5A);
    @(negedge clk);
    check("t1_drained", out_valid, 0);

    // Back-to-back items appear on consecutive cycles.
    exp2 = '{8'h0F, 8'h13, 8'h02, 8'hAA};
    nout = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        check($sformatf("t2_data%0d", nout), data_out, exp2[nout]);
        check($sformatf("t2_cycle%0d", nout), c, 4 + nout);
        nout++;
      end
      in_valid = (c < 4);
      case (c)
        0: begin data_in = 8'hF0; mode = 2'b10; end
        1: begin data_in = 8'h0F; mode = 2'b11; end
        2: begin data_in = 8'hFE; mode = 2'b11; end
        3: begin data_in = 8'hAA; mode = 2'b00; end
        default: ;
      endcase
      @(negedge clk);
    end
    check("t2_count", nout, 4);

    // Full stall: only 4 of 6 offered items fit.
    out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; data_in = 8'h10 + 8'(idx); mode = 2'b00;
      #1;
      if (in_ready) idx++;
      @(negedge clk);
    end
    in_valid = 1'b1; data_in = 8'h10 + 8'(idx);
    #1;
    check("t3_accepted", idx, 4);
    check("t3_in_ready", in_ready, 0);
    check("t3_out_valid", out_valid, 1);
    check("t3_head", data_out, 8'h10);
    @(negedge clk);
    check("t3_stable", data_out, 8'h10);
    got_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got_q.size() < 6; c++) begin
      if (out_valid) got_q.push_back(data_out);
      if (idx < 6) begin
        in_valid = 1'b1; data_in = 8'h10 + 8'(idx);
        #1;
        if (in_ready) idx++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("t3_count", got_q.size(), 6);
    for (int k = 0; k < 6 && k < got_q.size(); k++)
      check($sformatf("t3_order%0d", k), got_q[k], 8'h10 + 8'(k));

    // Bubbles: stages 0 and 2 full, 1 and 3 empty, output stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; data_in = 8'h20; mode = 2'b11;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); in_valid = 1'b1; data_in = 8'h30; mode = 2'b01;
    @(negedge clk); in_valid = 1'b1; data_in = 8'h41; mode = 2'b10;
    #1 check("t4_bubble_ready", in_ready, 1);
    @(negedge clk); in_valid = 1'b0;
    check("t4_out_valid", out_valid, 1);
    check("t4_head", data_out, 8'h24);
    @(negedge clk);
    check("t4_stable1", data_out, 8'h24);
    check("t4_gap_ready", in_ready, 1);
    @(negedge clk);
    check("t4_stable2", data_out, 8'h24);
    exp4 = '{8'h24, 8'h03, 8'h04};
    collect(3);
    for (int k = 0; k < 3 && k < got_q.size(); k++)
      check($sformatf("t4_order%0d", k), got_q[k], exp4[k]);

    // Flush with three items in flight and a same-cycle offer.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; data_in = 8'h60 + 8'(k); mode = 2'b00;
      @(negedge clk);
    end
    flush = 1'b1; in_valid = 1'b1; data_in = 8'h77;
    #1 check("t5_flush_ready", in_ready, 1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("t5_out_valid", out_valid, 0);
`ifdef PIPE_STATS_EN
    check("t5_count_clr", item_count, 0);
`endif
    nout = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) nout++;
      @(negedge clk);
    end
    check("t5_no_output", nout, 0);

    // Asynchronous reset mid-stream, after two completed transfers.
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; data_in = 8'h50 + 8'(k); mode = 2'b00;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("t6_pre_data", data_out, 8'h52);
`ifdef PIPE_STATS_EN
    check("t6_pre_count", item_count, 2);
`endif
    #2 reset = 1'b1;
    #1;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_data", data_out, 0);
`ifdef PIPE_STATS_EN
    check("t6_rst_count", item_count, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    nout = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) nout++;
      @(negedge clk);
    end
    check("t6_no_partial", nout, 0);
    check("t6_in_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
